// File: rtl/bit_serializer.sv
// bit_serializer: streams valid/ready words out one bit per clock to the sequence detector
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             x_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic x_out_n, x_valid_n, x_last_n, accept, advance;
  // state, shifter and registered serial outputs; everything freezes while en is low
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      x_out   <= 1'b0;
      x_valid <= 1'b0;
      x_last  <= 1'b0;
    end else if (en) begin
      state   <= state_n;
      shreg   <= shreg_n;
      cnt     <= cnt_n;
      x_out   <= x_out_n;
      x_valid <= x_valid_n;
      x_last  <= x_last_n;
    end
  // stay in SHIFT while bits remain or a new word is taken on the last bit
  always_comb
    state_n = (accept || advance) ? SHIFT : IDLE;
  // handshake plus next shifter/output values; accept and advance are mutually exclusive
  always_comb begin
    busy      = state == SHIFT;
    din_ready = en && (state == IDLE || cnt == LAST);
    accept    = din_valid && din_ready;
    advance   = busy && cnt != LAST;
    shreg_n   = accept ? din : advance ? (MSB_FIRST ? shreg << 1 : shreg >> 1) : '0;
    cnt_n     = advance ? cnt + CW'(1) : '0;
    x_out_n   = accept ? (MSB_FIRST ? din[WIDTH-1] : din[0])
              : advance ? (MSB_FIRST ? shreg[WIDTH-2] : shreg[1]) : 1'b0;
    x_valid_n = state_n == SHIFT;
    x_last_n  = advance && cnt == PENULT;
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench for MSB-first and LSB-first serializer instances
module tb_bit_serializer;
  logic clk = 1'b0, reset = 1'b0, en = 1'b1, en_q = 1'b1;
  logic [7:0] din1 = '0, din0 = '0;
  logic dv1 = 1'b0, dv0 = 1'b0;
  logic r1, xo1, xv1, xl1, b1, r0, xo0, xv0, xl0, b0;
  logic [1:0] q1[$], q0[$];
  int vectors = 0, errors = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .reset(reset), .en(en), .din(din1), .din_valid(dv1),
    .din_ready(r1), .x_out(xo1), .x_valid(xv1), .x_last(xl1), .busy(b1));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .reset(reset), .en(en), .din(din0), .din_valid(dv0),
    .din_ready(r0), .x_out(xo0), .x_valid(xv0), .x_last(xl0), .busy(b0));

  always #5 clk = ~clk;
  always @(posedge clk) en_q = en;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // expected bits given in output order, x_last on every 8th bit
  task automatic push(input bit which, input logic [15:0] bits, input int n);
    logic [1:0] item;
    for (int i = 0; i < n; i++) begin
      item = {bits[n-1-i], i % 8 == 7};
      if (which) q1.push_back(item);
      else q0.push_back(item);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q1.size() == 0 && q0.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (q1.size() != 0 || q0.size() != 0) begin
      chk("drain_timeout", 8'(q1.size() + q0.size()), 8'd0);
      q1.delete();
      q0.delete();
    end
  endtask

  // monitors: pop one expected {bit,last} per enabled cycle with a valid bit
  always @(negedge clk)
    if (reset && en_q && xv1) begin
      if (q1.size() == 0) chk("msb_unexpected_bit", {6'd0, xo1, xl1}, 8'hee);
      else chk("msb_bit_last", {6'd0, xo1, xl1}, {6'd0, q1.pop_front()});
    end
  always @(negedge clk)
    if (reset && en_q && xv0) begin
      if (q0.size() == 0) chk("lsb_unexpected_bit", {6'd0, xo0, xl0}, 8'hee);
      else chk("lsb_bit_last", {6'd0, xo0, xl0}, {6'd0, q0.pop_front()});
    end

  initial begin
    repeat (2) tick();
    chk("reset_xvalid", {7'd0, xv1}, 8'd0);
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("idle_xvalid", {7'd0, xv1}, 8'd0);
    chk("idle_xout", {7'd0, xo1}, 8'd0);
    chk("idle_ready", {6'd0, r1, r0}, 8'd3);
    chk("idle_busy", {6'd0, b1, b0}, 8'd0);
    // single MSB-first word
    tick();
    din1 = 8'b1110_0001;
    dv1 = 1'b1;
    push(1'b1, 16'b1110_0001, 8);
    tick();
    dv1 = 1'b0;
    drain();
    tick();
    @(negedge clk);
    chk("after_word_xvalid", {7'd0, xv1}, 8'd0);
    chk("after_word_busy", {7'd0, b1}, 8'd0);
    chk("after_word_xlast", {7'd0, xl1}, 8'd0);
    // back-to-back words with din_valid held
    tick();
    din1 = 8'hF0;
    dv1 = 1'b1;
    push(1'b1, 16'b1111_0000_0000_1111, 16);
    @(negedge clk);
    chk("b2b_ready_c0", {7'd0, r1}, 8'd1);
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 1) din1 = 8'h0F;
      if (c == 9) dv1 = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b_xvalid_c%0d", c), {7'd0, xv1}, 8'd1);
      chk($sformatf("b2b_ready_c%0d", c), {7'd0, r1}, {7'd0, c == 8});
    end
    drain();
    tick();
    // LSB-first word
    din0 = 8'b0000_0111;
    dv0 = 1'b1;
    push(1'b0, 16'b1110_0000, 8);
    tick();
    dv0 = 1'b0;
    drain();
    tick();
    @(negedge clk);
    chk("lsb_after_busy", {7'd0, b0}, 8'd0);
    // stall three cycles on the third bit of A5
    tick();
    din1 = 8'hA5;
    dv1 = 1'b1;
    push(1'b1, 16'b1010_0101, 8);
    tick();
    dv1 = 1'b0;
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("stall_xout", {6'd0, xv1, xo1}, 8'd3);
      chk("stall_ready", {7'd0, r1}, 8'd0);
    end
    tick();
    en = 1'b1;
    drain();
    tick();
    // asynchronous reset during the fourth bit of FF
    din1 = 8'hFF;
    dv1 = 1'b1;
    push(1'b1, 16'h00FF, 8);
    tick();
    dv1 = 1'b0;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_out", {5'd0, xv1, xo1, b1}, 8'd0);
    q1.delete();
    #1;
    reset = 1'b1;
    tick();
    din1 = 8'h00;
    dv1 = 1'b1;
    push(1'b1, 16'h0000, 8);
    tick();
    dv1 = 1'b0;
    drain();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
